relogio_controle: RTL and testbench

- Time-keeping and set-mode controller for the digital clock.
- Consumes the one-cycle 1 Hz enable pulse and two user buttons.
- Sequences the seconds/minutes/hours counters and the RUN / SET_HOUR / SET_MIN mode FSM.
- Drives the display path with the binary time fields, the current mode and a blink qualifier for the field being edited.

---
 rtl/relogio_controle.sv | 141 ++++++++++++++
 tb/tb_relogio_controle.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/relogio_controle.sv
// Time-keeping and set-mode controller for the digital clock.
// Runs h:m:s on the 1 Hz tick; RUN/SET_HOUR/SET_MIN editing with blink and timeout.
module relogio_controle #(
  parameter int HOURS_MAX   = 24,
  parameter int SET_TIMEOUT = 10
) (
  input  logic       controle_clock,
  input  logic       controle_reset,
  input  logic       controle_tick,
  input  logic       controle_btn_mode,
  input  logic       controle_btn_inc,
  output logic [4:0] controle_hours,
  output logic [5:0] controle_minutes,
  output logic [5:0] controle_seconds,
  output logic [1:0] controle_mode,
  output logic       controle_blink,
  output logic       controle_day_pulse
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  localparam logic [4:0] HOUR_LAST = 5'(HOURS_MAX - 1);
  localparam logic [5:0] TOUT      = 6'(SET_TIMEOUT);

  mode_e      mode_q, mode_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] tout_q, tout_d;
  logic       blink_q, blink_d;
  logic       day_q, day_d;
  logic       mode_hist_q;
  logic       inc_hist_q;
  logic       mode_p;
  logic       inc_p;

  // mode press masks a coincident inc press
  assign mode_p = controle_btn_mode & ~mode_hist_q;
  assign inc_p  = controle_btn_inc & ~inc_hist_q & ~mode_p;

  always_comb begin
    mode_d  = mode_q;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tout_d  = tout_q;
    blink_d = blink_q;
    day_d   = 1'b0;
    unique case (mode_q)
      RUN: begin
        blink_d = 1'b1;
        if (controle_tick) begin
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d = '0;
              if (hours_q == HOUR_LAST) begin
                hours_d = '0;
                day_d   = 1'b1;
              end else begin
                hours_d = hours_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_p) begin
          mode_d = SET_HOUR;
          tout_d = '0;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (mode_p || inc_p) begin
          tout_d  = '0;
          blink_d = 1'b1;
          if (mode_p) begin
            if (mode_q == SET_HOUR) begin
              mode_d = SET_MIN;
            end else begin
              mode_d = RUN;
              sec_d  = '0;
            end
          end else if (mode_q == SET_HOUR) begin
            hours_d = (hours_q == HOUR_LAST) ? '0 : hours_q + 5'd1;
          end else begin
            min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
          end
        end else if (controle_tick) begin
          if (tout_q + 6'd1 == TOUT) begin
            mode_d  = RUN;
            tout_d  = '0;
            blink_d = 1'b1;
          end else begin
            tout_d  = tout_q + 6'd1;
            blink_d = ~blink_q;
          end
        end
      end
      default: mode_d = RUN;
    endcase
  end

  always_ff @(posedge controle_clock or posedge controle_reset) begin
    if (controle_reset) begin
      mode_q      <= RUN;
      hours_q     <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      tout_q      <= '0;
      blink_q     <= 1'b1;
      day_q       <= 1'b0;
      mode_hist_q <= 1'b0;
      inc_hist_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      hours_q     <= hours_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tout_q      <= tout_d;
      blink_q     <= blink_d;
      day_q       <= day_d;
      mode_hist_q <= controle_btn_mode;
      inc_hist_q  <= controle_btn_inc;
    end
  end

  assign controle_hours     = hours_q;
  assign controle_minutes   = min_q;
  assign controle_seconds   = sec_q;
  assign controle_mode      = mode_q;
  assign controle_blink     = blink_q;
  assign controle_day_pulse = day_q;

endmodule

// File: tb/tb_relogio_controle.sv
// Scoreboard bench for relogio_controle: directed stimulus pushes
// hand-computed snapshots; a monitor process pops and compares.
module tb_relogio_controle;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       bmode;
  logic       binc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       day;

  relogio_controle #(
    .HOURS_MAX  (24),
    .SET_TIMEOUT(10)
  ) dut (
    .controle_clock    (clk),
    .controle_reset    (rst),
    .controle_tick     (tick),
    .controle_btn_mode (bmode),
    .controle_btn_inc  (binc),
    .controle_hours    (hours),
    .controle_minutes  (minutes),
    .controle_seconds  (seconds),
    .controle_mode     (mode),
    .controle_blink    (blink),
    .controle_day_pulse(day)
  );

  typedef struct {
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       bl;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expected snapshot per sample strobe.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: no expected entry");
      end else begin
        e = sb.pop_front();
        if (hours !== e.h || minutes !== e.m ||
            seconds !== e.s || mode !== e.md ||
            blink !== e.bl || day !== e.dp) begin
          errors++;
          $display({"FAIL %s: got %0d:%0d:%0d mode=%0d",
                    " blink=%0d day=%0d, want %0d:%0d:%0d",
                    " mode=%0d blink=%0d day=%0d"},
                   e.name, hours, minutes, seconds, mode,
                   blink, day, e.h, e.m, e.s, e.md, e.bl,
                   e.dp);
        end
      end
    end
  end

  task automatic expect_st(input string n,
                           input int h, input int m,
                           input int s, input int md,
                           input int bl, input int dp);
    exp_t e;
    e.name = n;
    e.h    = 5'(h);
    e.m    = 6'(m);
    e.s    = 6'(s);
    e.md   = 2'(md);
    e.bl   = 1'(bl);
    e.dp   = 1'(dp);
    sb.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic press_mode();
    bmode = 1'b1;
    cyc();
    bmode = 1'b0;
    cyc();
  endtask

  task automatic press_inc();
    binc = 1'b1;
    cyc();
    binc = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // From RUN 00:00:00, edit to h:m and return to RUN (seconds 0)
  task automatic set_time(input int h, input int m);
    press_mode();
    repeat (h) press_inc();
    press_mode();
    repeat (m) press_inc();
    press_mode();
  endtask

  initial begin
    rst   = 1'b1;
    tick  = 1'b0;
    bmode = 1'b0;
    binc  = 1'b0;
    #2;
    expect_st("reset_initial", 0, 0, 0, 0, 1, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Async reset in the middle of a SET_MIN edit
    set_time(12, 34);
    repeat (56) tick1();
    press_mode();
    press_mode();
    expect_st("pre_reset_12_34_56", 12, 34, 56, 2, 1, 0);
    rst = 1'b1;
    #2;
    expect_st("async_reset", 0, 0, 0, 0, 1, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Midnight rollover
    set_time(23, 59);
    expect_st("load_23_59", 23, 59, 0, 0, 1, 0);
    repeat (58) tick1();
    expect_st("run_23_59_58", 23, 59, 58, 0, 1, 0);
    tick1();
    expect_st("run_23_59_59", 23, 59, 59, 0, 1, 0);
    tick1();
    expect_st("rollover", 0, 0, 0, 0, 1, 1);
    cyc();
    expect_st("day_pulse_one_cycle", 0, 0, 0, 0, 1, 0);

    // Edit sequence from 10:20:30
    do_reset();
    set_time(10, 20);
    repeat (30) tick1();
    expect_st("run_10_20_30", 10, 20, 30, 0, 1, 0);
    press_mode();
    expect_st("enter_set_hour", 10, 20, 30, 1, 1, 0);
    tick1();
    expect_st("set_hour_tick_hold", 10, 20, 30, 1, 0, 0);
    repeat (3) press_inc();
    expect_st("hour_plus3", 13, 20, 30, 1, 1, 0);
    press_mode();
    expect_st("enter_set_min", 13, 20, 30, 2, 1, 0);
    tick1();
    expect_st("set_min_tick1", 13, 20, 30, 2, 0, 0);
    tick1();
    expect_st("set_min_tick2", 13, 20, 30, 2, 1, 0);
    repeat (2) press_inc();
    press_mode();
    expect_st("edit_done_13_22", 13, 22, 0, 0, 1, 0);

    // Hour wrap in SET_HOUR, and held button
    press_mode();
    repeat (10) press_inc();
    expect_st("set_hour_23", 23, 22, 0, 1, 1, 0);
    binc = 1'b1;
    cyc();
    expect_st("hour_wrap_no_day", 0, 22, 0, 1, 1, 0);
    binc = 1'b0;
    cyc();
    binc = 1'b1;
    repeat (100) cyc();
    binc = 1'b0;
    cyc();
    expect_st("held_inc_single", 1, 22, 0, 1, 1, 0);

    // Timeout out of SET_MIN keeps edit and seconds
    press_mode();
    press_mode();
    repeat (7) tick1();
    press_mode();
    press_mode();
    press_inc();
    expect_st("set_min_01_23_07", 1, 23, 7, 2, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      tick1();
      expect_st($sformatf("timeout_tick%0d", k),
                1, 23, 7, 2, (k % 2 == 0) ? 1 : 0, 0);
    end
    tick1();
    expect_st("timeout_to_run", 1, 23, 7, 0, 1, 0);
    tick1();
    expect_st("run_after_timeout", 1, 23, 8, 0, 1, 0);

    // mode + inc together in SET_HOUR
    press_mode();
    bmode = 1'b1;
    binc  = 1'b1;
    cyc();
    expect_st("mode_beats_inc", 1, 23, 8, 2, 1, 0);
    bmode = 1'b0;
    binc  = 1'b0;
    cyc();

    // tick + inc at timeout count 9
    repeat (9) tick1();
    expect_st("count9", 1, 23, 8, 2, 0, 0);
    tick = 1'b1;
    binc = 1'b1;
    cyc();
    expect_st("tick_inc_press_wins", 1, 24, 8, 2, 1, 0);
    tick = 1'b0;
    binc = 1'b0;
    cyc();
    repeat (9) tick1();
    expect_st("counter_was_cleared", 1, 24, 8, 2, 0, 0);
    tick1();
    expect_st("second_timeout", 1, 24, 8, 0, 1, 0);

    // tick + mode in RUN
    tick  = 1'b1;
    bmode = 1'b1;
    cyc();
    expect_st("tick_mode_run", 1, 24, 9, 1, 1, 0);
    tick  = 1'b0;
    bmode = 1'b0;
    cyc();

    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, want 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
